// File: rtl/sha256_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : sha256_round_ctrl
// Brief   : Sequences one SHA-256 block compression, one round per clock.
// Revision: 1.0
// ============================================================================
module sha256_round_ctrl #(
    parameter int ROUNDS = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [255:0] hin,
    input  logic         msg_valid,
    output logic         msg_ready,
    input  logic [31:0]  msg_word,
    output logic [5:0]   k_idx,
    input  logic [31:0]  k_word,
    output logic         busy,
    output logic         dout_valid,
    output logic [255:0] dout,
    input  logic         dout_ack
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ROUND = 3'd2,
        S_FINAL = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [5:0] c_last_round = 6'(ROUNDS - 1);

    state_t       r_state;
    logic [255:0] r_hin;
    logic [31:0]  r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h;
    logic [31:0]  r_w [16];
    logic [3:0]   r_wcnt;

    logic [31:0]  w_wt;
    logic [31:0]  w_t1;
    logic [31:0]  w_t2;

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'd0, x[31:10]};
    endfunction

    function automatic logic [31:0] f_ch(input logic [31:0] e, input logic [31:0] f,
                                         input logic [31:0] g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic logic [31:0] f_maj(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

    // The buffer is a shift register: r_w[0] is always W[t-16], so the
    // schedule taps sit at fixed positions (t-15 -> 1, t-7 -> 9, t-2 -> 14).
    always_comb begin
        w_wt = '0;
        w_t1 = '0;
        w_t2 = '0;
        if (k_idx < 6'd16) begin
            w_wt = r_w[0];
        end else begin
            w_wt = ssig1(r_w[14]) + r_w[9] + ssig0(r_w[1]) + r_w[0];
        end
        w_t1 = r_h + bsig1(r_e) + f_ch(r_e, r_f, r_g) + k_word + w_wt;
        w_t2 = bsig0(r_a) + f_maj(r_a, r_b, r_c);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_hin      <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_c        <= '0;
            r_d        <= '0;
            r_e        <= '0;
            r_f        <= '0;
            r_g        <= '0;
            r_h        <= '0;
            for (int i = 0; i < 16; i++) begin
                r_w[i] <= '0;
            end
            r_wcnt     <= '0;
            k_idx      <= '0;
            msg_ready  <= 1'b0;
            busy       <= 1'b0;
            dout_valid <= 1'b0;
            dout       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_hin     <= hin;
                        {r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h} <= hin;
                        r_wcnt    <= '0;
                        msg_ready <= 1'b1;
                        busy      <= 1'b1;
                        r_state   <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (msg_valid) begin
                        for (int i = 0; i < 15; i++) begin
                            r_w[i] <= r_w[i + 1];
                        end
                        r_w[15] <= msg_word;
                        r_wcnt  <= r_wcnt + 4'd1;
                        if (r_wcnt == 4'd15) begin
                            msg_ready <= 1'b0;
                            k_idx     <= '0;
                            r_state   <= S_ROUND;
                        end
                    end
                end
                S_ROUND: begin
                    for (int i = 0; i < 15; i++) begin
                        r_w[i] <= r_w[i + 1];
                    end
                    r_w[15] <= w_wt;
                    r_h     <= r_g;
                    r_g     <= r_f;
                    r_f     <= r_e;
                    r_e     <= r_d + w_t1;
                    r_d     <= r_c;
                    r_c     <= r_b;
                    r_b     <= r_a;
                    r_a     <= w_t1 + w_t2;
                    if (k_idx == c_last_round) begin
                        k_idx   <= '0;
                        r_state <= S_FINAL;
                    end else begin
                        k_idx   <= k_idx + 6'd1;
                    end
                end
                S_FINAL: begin
                    dout <= {r_hin[255:224] + r_a, r_hin[223:192] + r_b,
                             r_hin[191:160] + r_c, r_hin[159:128] + r_d,
                             r_hin[127:96]  + r_e, r_hin[95:64]   + r_f,
                             r_hin[63:32]   + r_g, r_hin[31:0]    + r_h};
                    dout_valid <= 1'b1;
                    r_state    <= S_DONE;
                end
                S_DONE: begin
                    if (dout_ack) begin
                        dout_valid <= 1'b0;
                        busy       <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sha256_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_sha256_round_ctrl
// Brief   : Self-checking bench for sha256_round_ctrl with a digest scoreboard.
// Revision: 1.0
// ============================================================================
module tb_sha256_round_ctrl;

    localparam logic [31:0] KT [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [255:0] H_INIT    = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [511:0] ABC_BLK   = {32'h61626380, 448'd0, 32'h00000018};
    localparam logic [255:0] ABC_DIG   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'd0};
    localparam logic [255:0] EMPTY_DIG = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [255:0] hin;
    logic         msg_valid;
    logic         msg_ready;
    logic [31:0]  msg_word;
    logic [5:0]   k_idx;
    logic [31:0]  k_word;
    logic         busy;
    logic         dout_valid;
    logic [255:0] dout;
    logic         dout_ack;

    int           errors = 0;
    int           checks = 0;
    int           cyc = 0;
    logic [255:0] exp_q [$];

    sha256_round_ctrl #(.ROUNDS(64)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .hin        (hin),
        .msg_valid  (msg_valid),
        .msg_ready  (msg_ready),
        .msg_word   (msg_word),
        .k_idx      (k_idx),
        .k_word     (k_word),
        .busy       (busy),
        .dout_valid (dout_valid),
        .dout       (dout),
        .dout_ack   (dout_ack)
    );

    assign k_word = KT[k_idx];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Straight textbook compression with a fully expanded 64-word schedule.
    function automatic logic [255:0] sha_model(input logic [255:0] h, input logic [511:0] blk);
        logic [31:0]  w [64];
        logic [31:0]  v [8];
        logic [31:0]  t1, t2, s0, s1;
        logic [255:0] r;
        for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0   = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
            s1   = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        for (int i = 0; i < 8; i++) v[i] = h[255 - 32*i -: 32];
        for (int i = 0; i < 64; i++) begin
            t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
               + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[i] + w[i];
            t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
               + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int j = 7; j > 0; j--) v[j] = v[j-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = h[255 - 32*i -: 32] + v[i];
        return r;
    endfunction

    // Pushes the expected digest, issues start, then feeds the 16 words.
    task automatic send_block(input logic [255:0] h, input logic [511:0] blk, input bit toggle,
                              output int t_start, output int t_last, output bit ok);
        int i;
        int budget;
        bit ph;
        exp_q.push_back(sha_model(h, blk));
        @(negedge clk);
        start   = 1'b1;
        hin     = h;
        t_start = cyc;
        @(negedge clk);
        start  = 1'b0;
        i      = 0;
        ph     = 1'b0;
        budget = 0;
        ok     = 1'b0;
        t_last = cyc;
        while (i < 16 && budget < 100) begin
            if (toggle && ph) begin
                msg_valid = 1'b0;
            end else begin
                msg_valid = 1'b1;
                msg_word  = blk[511 - 32*i -: 32];
            end
            ph = !ph;
            if (msg_valid && msg_ready) begin
                i++;
                if (i == 16) begin
                    t_last = cyc;
                    ok     = 1'b1;
                end
            end
            budget++;
            @(negedge clk);
        end
        msg_valid = 1'b0;
    endtask

    task automatic collect(output logic [255:0] d, output int t_valid, output bit got);
        got     = 1'b0;
        d       = '0;
        t_valid = 0;
        for (int n = 0; n < 300 && !got; n++) begin
            if (dout_valid) begin
                got     = 1'b1;
                d       = dout;
                t_valid = cyc;
            end else begin
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; hin = '0; msg_valid = 1'b0; msg_word = '0; dout_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (msg_ready !== 1'b0) begin errors++; $display("FAIL reset_msg_ready: got %b expected 0", msg_ready); end
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_dout_valid: got %b expected 0", dout_valid); end
        checks++; if (k_idx !== 6'd0) begin errors++; $display("FAIL reset_k_idx: got %0d expected 0", k_idx); end
        checks++; if (dout !== 256'd0) begin errors++; $display("FAIL reset_dout: got %h expected 0", dout); end
        rst_n = 1'b1;
    endtask

    task automatic test_abc();
        int ts, tl, tv;
        bit ok, got;
        logic [255:0] d, e;
        send_block(H_INIT, ABC_BLK, 1'b0, ts, tl, ok);
        checks++; if (!ok) begin errors++; $display("FAIL abc_load: words not all accepted, got 0 expected 1"); end
        collect(d, tv, got);
        checks++; if (!got) begin errors++; $display("FAIL abc_timeout: dout_valid got 0 expected 1"); end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        checks++; if (d !== e) begin errors++; $display("FAIL abc_model: got %h expected %h", d, e); end
        checks++; if (d !== ABC_DIG) begin errors++; $display("FAIL abc_digest: got %h expected %h", d, ABC_DIG); end
        checks++; if (tv - tl != 66) begin errors++; $display("FAIL abc_latency: got %0d expected 66", tv - tl); end
        dout_ack = 1'b1;
        @(negedge clk);
        dout_ack = 1'b0;
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL abc_ack_valid: got %b expected 0", dout_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abc_ack_busy: got %b expected 0", busy); end
        checks++; if (dout !== ABC_DIG) begin errors++; $display("FAIL abc_dout_hold: got %h expected %h", dout, ABC_DIG); end
    endtask

    task automatic test_empty();
        int ts, tl, tv;
        bit ok, got;
        logic [255:0] d, e;
        send_block(H_INIT, EMPTY_BLK, 1'b0, ts, tl, ok);
        collect(d, tv, got);
        checks++; if (!got) begin errors++; $display("FAIL empty_timeout: dout_valid got 0 expected 1"); end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        checks++; if (d !== e) begin errors++; $display("FAIL empty_model: got %h expected %h", d, e); end
        checks++; if (d !== EMPTY_DIG) begin errors++; $display("FAIL empty_digest: got %h expected %h", d, EMPTY_DIG); end
        dout_ack = 1'b1;
        @(negedge clk);
        dout_ack = 1'b0;
    endtask

    task automatic test_backpressure();
        int ts, tl, tv;
        bit ok, got;
        logic [255:0] d, e;
        send_block(H_INIT, ABC_BLK, 1'b1, ts, tl, ok);
        collect(d, tv, got);
        checks++; if (!got) begin errors++; $display("FAIL bp_timeout: dout_valid got 0 expected 1"); end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        checks++; if (d !== e) begin errors++; $display("FAIL bp_model: got %h expected %h", d, e); end
        checks++; if (d !== ABC_DIG) begin errors++; $display("FAIL bp_digest: got %h expected %h", d, ABC_DIG); end
        checks++; if (tl - ts != 31) begin errors++; $display("FAIL bp_load_cycles: got %0d expected 31", tl - ts); end
        checks++; if (tv - ts != 97) begin errors++; $display("FAIL bp_total_latency: got %0d expected 97", tv - ts); end
        dout_ack = 1'b1;
        @(negedge clk);
        dout_ack = 1'b0;
    endtask

    task automatic test_chaining();
        int ts, tl, tv;
        bit ok, got;
        logic [255:0] d, e;
        logic [511:0] blk2;
        for (int i = 0; i < 16; i++) blk2[511 - 32*i -: 32] = $urandom;
        send_block(ABC_DIG, blk2, 1'b0, ts, tl, ok);
        collect(d, tv, got);
        checks++; if (!got) begin errors++; $display("FAIL chain_timeout: dout_valid got 0 expected 1"); end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        checks++; if (d !== e) begin errors++; $display("FAIL chain_digest: got %h expected %h", d, e); end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL chain_hold_valid[%0d]: got %b expected 1", k, dout_valid); end
            checks++; if (dout !== e) begin errors++; $display("FAIL chain_hold_dout[%0d]: got %h expected %h", k, dout, e); end
        end
        dout_ack = 1'b1;
        @(negedge clk);
        dout_ack = 1'b0;
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL chain_ack_valid: got %b expected 0", dout_valid); end
    endtask

    task automatic test_reset_mid();
        int ts, tl, tv;
        bit ok, got;
        logic [255:0] d, e;
        send_block(H_INIT, ABC_BLK, 1'b0, ts, tl, ok);
        for (int n = 0; n < 100 && k_idx != 6'd30; n++) @(negedge clk);
        checks++; if (k_idx !== 6'd30) begin errors++; $display("FAIL rst_mid_reach: k_idx got %0d expected 30", k_idx); end
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b expected 0", dout_valid); end
        checks++; if (k_idx !== 6'd0) begin errors++; $display("FAIL rst_mid_k_idx: got %0d expected 0", k_idx); end
        checks++; if (dout !== 256'd0) begin errors++; $display("FAIL rst_mid_dout: got %h expected 0", dout); end
        checks++;
        if ({dut.r_a, dut.r_b, dut.r_c, dut.r_d, dut.r_e, dut.r_f, dut.r_g, dut.r_h} !== 256'd0) begin
            errors++;
            $display("FAIL rst_mid_state: got %h expected 0",
                     {dut.r_a, dut.r_b, dut.r_c, dut.r_d, dut.r_e, dut.r_f, dut.r_g, dut.r_h});
        end
        @(negedge clk);
        rst_n = 1'b1;
        if (exp_q.size() > 0) void'(exp_q.pop_back());
        send_block(H_INIT, ABC_BLK, 1'b0, ts, tl, ok);
        collect(d, tv, got);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        checks++; if (d !== e || d !== ABC_DIG) begin errors++; $display("FAIL rst_mid_rerun: got %h expected %h", d, ABC_DIG); end
        dout_ack = 1'b1;
        @(negedge clk);
        dout_ack = 1'b0;
    endtask

    task automatic test_spurious();
        int ts, tl, tv;
        bit ok, got;
        logic [255:0] d, e;
        @(negedge clk);
        msg_valid = 1'b1;
        msg_word  = 32'hffffffff;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++; if (msg_ready !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL idle_msg_valid[%0d]: ready/busy got %b%b expected 00", k, msg_ready, busy); end
        end
        msg_valid = 1'b0;
        send_block(H_INIT, ABC_BLK, 1'b0, ts, tl, ok);
        start     = 1'b1;
        hin       = ~H_INIT;
        dout_ack  = 1'b1;
        msg_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++; if (busy !== 1'b1 || msg_ready !== 1'b0) begin errors++; $display("FAIL round_spurious[%0d]: busy/ready got %b%b expected 10", k, busy, msg_ready); end
        end
        start     = 1'b0;
        dout_ack  = 1'b0;
        msg_valid = 1'b0;
        collect(d, tv, got);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        checks++; if (d !== e || d !== ABC_DIG) begin errors++; $display("FAIL spurious_digest: got %h expected %h", d, ABC_DIG); end
        checks++; if (tv - tl != 66) begin errors++; $display("FAIL spurious_latency: got %0d expected 66", tv - tl); end
        start    = 1'b1;
        hin      = H_INIT;
        dout_ack = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        dout_ack = 1'b0;
        checks++; if (busy !== 1'b0 || dout_valid !== 1'b0) begin errors++; $display("FAIL done_start_ack: busy/valid got %b%b expected 00", busy, dout_valid); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL done_start_ignored: busy got %b expected 0", busy); end
    endtask

    initial begin
        test_reset();
        test_abc();
        test_empty();
        test_backpressure();
        test_chaining();
        test_reset_mid();
        test_spurious();
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
